// File: rtl/fft8_twiddle_stage_if.sv
// Sample stream bundle for the 8-point FFT inter-stage twiddle multiplier.
// The slave side is the multiplier, the master side feeds and observes it.
interface fft8_twiddle_stage_if #(
  parameter int N = 4
);
  localparam int W = 2 ** N;

  logic                in_valid;
  logic                in_sof;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_sof;
  logic                out_eof;
  logic [2:0]          out_idx;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;

  modport master (
    output in_valid, in_sof, in_re, in_im,
    input  out_valid, out_sof, out_eof, out_idx, out_re, out_im
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im,
    output out_valid, out_sof, out_eof, out_idx, out_re, out_im
  );
endinterface

// File: rtl/fft8_twiddle_stage.sv
// Inter-stage twiddle multiplier for the 8-point radix-2 DIF FFT.
// Samples 4..7 of each frame are rotated by W8^0..W8^3; W8^1 and W8^3 use a
// shift-add approximation of 1/sqrt(2). Fixed 3-cycle latency, no stalls.
module fft8_twiddle_stage #(
  parameter int N = 4
) (
  input logic                  clk,
  input logic                  rst,
  fft8_twiddle_stage_if.slave  bus
);
  localparam int W = 2 ** N;

  typedef enum logic [1:0] {TW0 = 2'd0, TW1 = 2'd1, TW2 = 2'd2, TW3 = 2'd3} tw_e;

  logic [2:0]          cnt;
  logic [2:0]          cur_idx;
  tw_e                 cur_k;

  logic                s1_valid;
  logic [2:0]          s1_idx;
  tw_e                 s1_k;
  logic signed [W-1:0] s1_re, s1_im, s1_p, s1_m;

  logic                s2_valid;
  logic [2:0]          s2_idx;
  tw_e                 s2_k;
  logic signed [W-1:0] s2_re, s2_im;
  logic signed [W-1:0] s2_pa, s2_pb, s2_pc, s2_ma, s2_mb, s2_mc;

  logic                s3_valid;
  logic [2:0]          s3_idx;
  tw_e                 s3_k;
  logic signed [W-1:0] s3_re, s3_im, s3_dp, s3_dm;

  logic signed [W-1:0] mux_re, mux_im;

  // Index of the incoming sample and the twiddle it selects.
  always_comb begin
    cur_idx = bus.in_sof ? 3'd0 : cnt;
    cur_k   = TW0;
    if (cur_idx[2]) cur_k = tw_e'(cur_idx[1:0]);
  end

  // Frame position counter; advances only on valid samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (bus.in_valid) cnt <= cur_idx + 3'd1;
  end

  // S1: capture operands and the pre-scaling sum/difference (wrapping).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_k     <= TW0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_p     <= '0;
      s1_m     <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_idx   <= cur_idx;
      s1_k     <= cur_k;
      s1_re    <= bus.in_re;
      s1_im    <= bus.in_im;
      s1_p     <= bus.in_re + bus.in_im;
      s1_m     <= bus.in_im - bus.in_re;
    end
  end

  // S2: first half of the 1/sqrt(2) shift-add tree for both p and m.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_k     <= TW0;
      s2_re    <= '0;
      s2_im    <= '0;
      s2_pa    <= '0;
      s2_pb    <= '0;
      s2_pc    <= '0;
      s2_ma    <= '0;
      s2_mb    <= '0;
      s2_mc    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_k     <= s1_k;
      s2_re    <= s1_re;
      s2_im    <= s1_im;
      s2_pa    <= (s1_p >>> 1) + (s1_p >>> 3);
      s2_pb    <= (s1_p >>> 4) + (s1_p >>> 6);
      s2_pc    <= s1_p >>> 8;
      s2_ma    <= (s1_m >>> 1) + (s1_m >>> 3);
      s2_mb    <= (s1_m >>> 4) + (s1_m >>> 6);
      s2_mc    <= s1_m >>> 8;
    end
  end

  // S3: final scaled sums, unscaled operands delayed alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid <= 1'b0;
      s3_idx   <= '0;
      s3_k     <= TW0;
      s3_re    <= '0;
      s3_im    <= '0;
      s3_dp    <= '0;
      s3_dm    <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_idx   <= s2_idx;
      s3_k     <= s2_k;
      s3_re    <= s2_re;
      s3_im    <= s2_im;
      s3_dp    <= s2_pa + s2_pb + s2_pc;
      s3_dm    <= s2_ma + s2_mb + s2_mc;
    end
  end

  // Twiddle rotation select feeding the output registers.
  always_comb begin
    mux_re = s3_re;
    mux_im = s3_im;
    case (s3_k)
      TW1: begin mux_re = s3_dp;  mux_im = s3_dm;  end
      TW2: begin mux_re = s3_im;  mux_im = -s3_re; end
      TW3: begin mux_re = s3_dm;  mux_im = -s3_dp; end
      default: ;
    endcase
  end

  // Output registers; data/index hold across bubbles so idle outputs stay 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
    end else begin
      bus.out_valid <= s3_valid;
      bus.out_sof   <= s3_valid && (s3_idx == 3'd0);
      bus.out_eof   <= s3_valid && (s3_idx == 3'd7);
      if (s3_valid) begin
        bus.out_idx <= s3_idx;
        bus.out_re  <= mux_re;
        bus.out_im  <= mux_im;
      end
    end
  end
endmodule

// File: doc/fft8_twiddle_stage.md
Name: fft8_twiddle_stage

Overview:
Inter-stage twiddle multiplier for the 8-point radix-2 DIF FFT. It sits between the first butterfly stage and the second. It consumes a stream of complex samples framed 8 per transform and multiplies samples 4..7 by W8^0..W8^3. The W8^1 and W8^3 products use the shift-add 1/√2 scaler. All outputs leave through a fixed-latency valid/frame-tagged pipeline.

Parameters:
N, 4, log2 of data width; each real/imag component is W = 2**N bits, signed two's complement.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input sample valid this cycle
in_sof  in  1  first sample of frame (index 0); qualified by in_valid
in_re  in  W  input real part
in_im  in  W  input imaginary part
out_valid  out  1  output sample valid
out_sof  out  1  output sample is index 0
out_eof  out  1  output sample is index 7
out_idx  out  3  index of output sample within frame
out_re  out  W  output real part
out_im  out  W  output imaginary part

Behaviour:
- Reset: all outputs are driven 0 while rst=0 and after release until the first valid sample emerges. All pipeline valid bits are cleared and the index counter is set to 0. Reset is asynchronous and acts mid-frame or mid-pipeline; in-flight samples are discarded, never emitted.
- Streaming, no backpressure: there is one sample per cycle maximum. Bubbles (in_valid=0) propagate as out_valid=0 with the same latency. The pipeline never stalls.
- Index counter cnt (3 bits):
  - A sample with in_valid=1 and in_sof=1 gets idx=0, and cnt becomes 1.
  - A sample with in_valid=1 and in_sof=0 gets idx=cnt, and cnt becomes cnt+1, wrapping 7→0.
  - When in_valid=0, cnt holds.
  - in_sof mid-frame restarts at idx 0; the partial frame is not flagged.
- Twiddle selection:
  - idx 0..3: k=0.
  - idx 4..7: k=idx[1:0].
- Arithmetic (all results mod 2^W, wrap, no saturation), with p=re+im, m=im-re, and D(x) = (x>>>1)+(x>>>3)+(x>>>4)+(x>>>6)+(x>>>8), using arithmetic shifts:
  - k=0: out=(re, im).
  - k=1: out=(D(p), D(m)).
  - k=2: out=(im, -re).
  - k=3: out=(D(m), -D(p)).
- Pipeline, latency exactly 3 cycles: a sample sampled at edge t appears on the outputs after edge t+3.
  - S1 registers p, m, re, im, k, idx and valid.
  - S2/S3 form the two-stage D() pipeline. Partial sums (x>>>1 + x>>>3) and (x>>>4 + x>>>6) are registered in S2 alongside the delayed x>>>8. The final sum is registered in S3.
  - Unscaled operands (k=0,2), idx and valid are delayed in matching S2/S3 registers.
  - The output mux feeds registered outputs, so all outputs change only on clk edges.
- Flags: out_sof=(out_idx==0)&out_valid and out_eof=(out_idx==7)&out_valid. Both are 0 when out_valid=0.
- Edge cases:
  - -2^(W-1) negates to itself.
  - p and m wrap on overflow before scaling.
  - D(-1) = -5 (each shift of -1 yields -1).

Test Plan:
- Reset: hold rst=0 with in_valid=1 and random data → all outputs 0. Release and drive nothing → out_valid=0 indefinitely.
- Frame pass-through and latency: 8 back-to-back samples (re=i*10, im=-i) starting with in_sof at edge t. Expect:
  - out_valid at t+3..t+10, with out_sof at t+3 and out_eof at t+10.
  - Indices 0..3 unchanged.
  - idx4 (k=0) = (40,-4).
  - idx6 (k=2) = (-6,-60).
- W8^1: idx5 with re=1000, im=0 → out=(705,-708). W8^3: idx7 with re=1000, im=0 → out=(-708,-705).
- Bubbles and restart: the frame has in_valid=0 gaps after idx 2 and idx 5 → outputs carry the same gaps 3 cycles later, with indices unbroken. A new in_sof at idx 3 gives that sample out_idx=0, and the next sample gets out_idx=1.
- Wrap extremes: idx6 with re=-32768, im=5 → out=(5,-32768). idx5 with re=32767, im=1 → p wraps to -32768 and out_re=D(-32768)=-23168. D(-1) check: idx7 with re=0, im=-1 → out_re=-5.
- Mid-pipeline reset: pulse rst=0 while 3 samples are in flight → none emerge. The next frame after release starts cleanly with out_idx=0.
